// File: rtl/param_buffer_arbiter_pkg.sv
// Shared types and helpers for param_buffer_arbiter: the buffer FSM state
// encoding and a pointer-relative round-robin pick usable for up to 16
// requesters.
package param_buffer_arbiter_pkg;

  localparam int MAX_REQ   = 16;
  localparam int MAX_IDX_W = 4;

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } state_t;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } pick_t;

  // First asserted bit of valid, searching from pointer+1 upward and
  // wrapping modulo num_req. The requester at pointer is checked last.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]   valid,
                                    input logic [MAX_IDX_W-1:0] pointer,
                                    input int                   num_req);
    pick_t res;
    int    cand;
    res = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      cand = (int'(pointer) + k) % num_req;
      if (k <= num_req && !res.found && valid[cand[MAX_IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[MAX_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/param_buffer_arbiter_rr_arbiter.sv
// Combinational round-robin pick: one-hot grant of the first valid
// requester after the pointer. Holds no state; the pointer is owned by the
// caller. Supports 2..16 requesters.
module rr_arbiter
  import param_buffer_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                       enable,
  input  logic [NUM_REQ-1:0]         valid,
  input  logic [$clog2(NUM_REQ)-1:0] pointer,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       grant_found
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [MAX_REQ-1:0] valid_ext;
  pick_t              pick;

  // Widen to the package search width, pick, and gate with enable.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional update, otherwise the unassigned paths infer latches.
    grant       = '0;
    valid_ext   = MAX_REQ'(valid);
    pick        = rr_pick(valid_ext, MAX_IDX_W'(pointer), NUM_REQ);
    grant_found = enable && pick.found;
    grant_idx   = pick.idx[IDX_W-1:0];
    if (grant_found) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/param_buffer_arbiter.sv
// Round-robin arbiter feeding a single data/address output buffer.
// NUM_REQ requesters compete for one register stage that is drained with
// valid/ready; a freed slot can be refilled in the same cycle, so the
// buffer sustains one transfer per clock. counter counts accepts modulo
// 2^COUNTER_WIDTH.
// Optional: define PARAM_BUFFER_ARBITER_LOCK_EN to add req_lock, which lets
// an accepted requester keep the grant while it holds req_valid and req_lock.
module param_buffer_arbiter
  import param_buffer_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int COUNTER_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
`ifdef PARAM_BUFFER_ARBITER_LOCK_EN
  input  logic [NUM_REQ-1:0]            req_lock,
`endif
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [ADDR_WIDTH-1:0]         out_addr,
  output logic [$clog2(NUM_REQ)-1:0]    out_src,
  output logic [COUNTER_WIDTH-1:0]      counter
);

  localparam int               IDX_W    = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  state_t             state, state_next;
  logic [IDX_W-1:0]   pointer;
  logic [IDX_W-1:0]   arb_pointer;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic               grant_found;
  logic               slot_free;
  logic               accept;

  assign out_valid = (state == ST_FULL);
  assign slot_free = (state == ST_EMPTY) || (out_valid && out_ready);
  assign req_ready = grant;
  assign accept    = |(req_valid & grant);

  // Buffer occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Next state: fill on accept, empty on drain without refill.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_EMPTY: if (accept) state_next = ST_FULL;
      ST_FULL:  if (out_ready && !accept) state_next = ST_EMPTY;
      default:  state_next = ST_EMPTY;
    endcase
  end

`ifdef PARAM_BUFFER_ARBITER_LOCK_EN
  // The pointer always names the last accepted requester, so a live lock is
  // honoured by searching from one below it; once released, the plain
  // pointer resumes arbitration from the requester after it.
  logic locked;
  logic lock_hold;

  assign lock_hold   = locked && req_valid[pointer] && req_lock[pointer];
  assign arb_pointer = !lock_hold        ? pointer  :
                       (pointer == '0)   ? LAST_IDX :
                                           pointer - IDX_W'(1);

  // Lock flag: taken from the accepted request, dropped once the owner
  // lets go while the slot is free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked <= 1'b0;
    end else if (accept) begin
      locked <= req_lock[grant_idx];
    end else if (slot_free && !lock_hold) begin
      locked <= 1'b0;
    end
  end
`else
  assign arb_pointer = pointer;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .enable      (slot_free),
    .valid       (req_valid),
    .pointer     (arb_pointer),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_found (grant_found)
  );

  // Output buffer, round-robin pointer and accept counter.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the buffer is a single register stage, so it is reset to keep
    // out_* deterministic after reset; it is not a memory array.
    if (!rst_n) begin
      out_data <= '0;
      out_addr <= '0;
      out_src  <= '0;
      pointer  <= LAST_IDX;
      counter  <= '0;
    end else if (accept) begin
      out_data <= req_data[int'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
      out_addr <= req_addr[int'(grant_idx) * ADDR_WIDTH +: ADDR_WIDTH];
      out_src  <= grant_idx;
      pointer  <= grant_idx;
      counter  <= counter + COUNTER_WIDTH'(1);
    end
  end

  // grant_found is implied by a non-zero grant; keep it observable.
  logic unused_ok;
  assign unused_ok = grant_found;

endmodule

// File: tb/tb_param_buffer_arbiter.sv
// Directed self-checking bench for param_buffer_arbiter (default
// parameters). Accepted requests are pushed to a scoreboard at grant time
// and popped when the buffer drains. Lock steps run only when
// PARAM_BUFFER_ARBITER_LOCK_EN is defined.
module tb_param_buffer_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 32;
  localparam int AW      = 16;
  localparam int CW      = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_lock;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic                 out_valid;
  logic                 out_ready;
  logic [DW-1:0]        out_data;
  logic [AW-1:0]        out_addr;
  logic [1:0]           out_src;
  logic [CW-1:0]        counter;

  logic [DW-1:0] data_tab [NUM_REQ];
  logic [AW-1:0] addr_tab [NUM_REQ];

  typedef struct {
    int            src;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
  } item_t;

  item_t sb[$];
  item_t mon_item;
  int    n_checks = 0;
  int    n_errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    req_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_data[i*DW +: DW] = data_tab[i];
      req_addr[i*AW +: AW] = addr_tab[i];
    end
  end

  param_buffer_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef PARAM_BUFFER_ARBITER_LOCK_EN
    .req_lock  (req_lock),
`endif
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_addr  (req_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_src   (out_src),
    .counter   (counter)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Call at a falling edge: checks req_ready and records the expected transfer.
  task automatic expect_grant(input string tag, input int idx);
    logic [NUM_REQ-1:0] exp;
    exp = (idx < 0) ? '0 : (NUM_REQ'(1) << idx);
    check(tag, 32'(req_ready), 32'(exp));
    if (idx >= 0) sb.push_back('{idx, data_tab[idx], addr_tab[idx]});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    #3;
    rst_n = 1'b1;
  endtask

  // Scoreboard drain: every transfer leaving the buffer must match the oldest grant.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $error("FAIL drain_unexpected: observed out_valid=1 src=%0d, expected no pending transfer", out_src);
      end else begin
        mon_item = sb.pop_front();
        check("drain_src",  32'(out_src),  32'(mon_item.src));
        check("drain_data", out_data,      mon_item.data);
        check("drain_addr", 32'(out_addr), 32'(mon_item.addr));
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_lock  = '0;
    out_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      data_tab[i] = '0;
      addr_tab[i] = '0;
    end

    // Reset state.
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_counter",   32'(counter),   32'd0);
    check("rst_out_data",  out_data,       32'd0);
    check("rst_out_src",   32'(out_src),   32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    next_cycle();

    // Single request from requester 2.
    data_tab[2] = 32'hDEADBEEF;
    addr_tab[2] = 16'h1234;
    req_valid   = 4'b0100;
    @(negedge clk);
    expect_grant("single_grant", 2);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    check("single_out_valid", 32'(out_valid), 32'd1);
    check("single_out_src",   32'(out_src),   32'd2);
    check("single_out_data",  out_data,       32'hDEADBEEF);
    check("single_out_addr",  32'(out_addr),  32'h1234);
    check("single_counter",   32'(counter),   32'd1);
    next_cycle();
    out_ready = 1'b1;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    check("single_drained", 32'(out_valid), 32'd0);

    // All four requesting with a ready sink: 0,1,2,3,0 without bubbles.
    next_cycle();
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      data_tab[i] = 32'h1111_0000 * (i + 1) + 32'(i);
      addr_tab[i] = 16'hA000 + 16'(i);
    end
    req_valid = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      expect_grant("rr_grant", k % 4);
      next_cycle();
    end

    // Backpressure for three cycles while FULL.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      expect_grant("bp_no_grant", -1);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_src",   32'(out_src),   32'd0);
      check("bp_out_data",  out_data,       data_tab[0]);
      check("bp_out_addr",  32'(out_addr),  32'(addr_tab[0]));
      check("bp_counter",   32'(counter),   32'd5);
      next_cycle();
    end
    out_ready = 1'b1;
    @(negedge clk);
    expect_grant("bp_release_grant", 1);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    expect_grant("bp_idle", -1);
    check("bp_counter_after", 32'(counter), 32'd6);
    next_cycle();
    @(negedge clk);
    check("bp_empty", 32'(out_valid), 32'd0);

    // Counter wrap: 256 back-to-back accepts from requester 1, then one more.
    next_cycle();
    do_reset();
    req_valid = 4'b0010;
    out_ready = 1'b1;
    for (int k = 0; k < 256; k++) begin
      data_tab[1] = 32'hA500_0000 | 32'(k);
      addr_tab[1] = 16'(k * 3);
      @(negedge clk);
      expect_grant("wrap_grant", 1);
      next_cycle();
    end
    req_valid = '0;
    @(negedge clk);
    check("wrap_counter_0", 32'(counter), 32'd0);
    next_cycle();
    req_valid = 4'b0010;
    @(negedge clk);
    expect_grant("wrap_grant_257", 1);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    check("wrap_counter_1", 32'(counter), 32'd1);

    // Asynchronous reset while FULL with counter=7.
    next_cycle();
    do_reset();
    req_valid = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      expect_grant("pre_rst_grant", k % 4);
      next_cycle();
    end
    req_valid = '0;
    out_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_counter",   32'(counter),   32'd7);
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_counter",   32'(counter),   32'd0);
    check("async_rst_out_data",  out_data,       32'd0);
    #1;
    rst_n = 1'b1;
    next_cycle();
    req_valid = 4'b1111;
    out_ready = 1'b1;
    @(negedge clk);
    expect_grant("post_rst_grant", 0);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    check("post_rst_counter", 32'(counter), 32'd1);

`ifdef PARAM_BUFFER_ARBITER_LOCK_EN
    // Requester 3 locked: four consecutive grants, then release goes to 0.
    next_cycle();
    req_lock  = 4'b1000;
    req_valid = 4'b1000;
    @(negedge clk);
    expect_grant("lock_grant", 3);
    next_cycle();
    req_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      expect_grant("lock_hold_grant", 3);
      next_cycle();
    end
    req_lock = '0;
    @(negedge clk);
    expect_grant("lock_release_grant", 0);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    check("lock_counter", 32'(counter), 32'd6);
`endif

    // Drain whatever remains and confirm every grant came out.
    next_cycle();
    req_valid = '0;
    out_ready = 1'b1;
    next_cycle();
    @(negedge clk);
    check("final_empty",      32'(out_valid), 32'd0);
    check("final_sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
